// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
//
// Multi-cycle control unit for a small MIPS-like datapath. Each instruction
// walks FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and returns to FETCH. The
// cycle in which an instruction completes raises pc_en for exactly one cycle.
// Register and memory writes are only issued in that completion cycle.
// Undefined instructions park the controller in HALT until reset.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   reset        : asynchronous active-low reset (0 = in reset)
//   en           : run enable, only looked at while in FETCH
//   opcode/func  : instruction[31:26] / instruction[5:0] from the datapath
//   mem_ready    : data memory has finished the current access
//   MemtoReg, Reg_Write, Mem_Read, Mem_Write, Branch, ALUsrc, JrSel, Jump
//                : single-bit datapath controls
//   regDst       : destination register select (00 rt, 01 rd, 10 r31)
//   writeDst     : write-back data select (00 mem/ALU mux, 01 PC+4,
//                  10 ALU result; 10 is never issued by this instruction set)
//   ALUOperation : 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//   pc_en        : PC update strobe, one cycle per completed instruction
//   illegal      : sticky undefined-instruction flag
//   retired      : wrapping count of completed instructions
// -----------------------------------------------------------------------------
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic        mem_ready,
    output logic        MemtoReg,
    output logic        Reg_Write,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        Branch,
    output logic        ALUsrc,
    output logic        JrSel,
    output logic        Jump,
    output logic [1:0]  regDst,
    output logic [1:0]  writeDst,
    output logic [3:0]  ALUOperation,
    output logic        pc_en,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_ILLEGAL, I_ADD, I_SUB, I_AND, I_OR, I_SLT, I_JR,
        I_LW, I_SW, I_BEQ, I_ADDI, I_SLTI, I_J, I_JAL
    } instr_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;
    localparam logic [1:0] WD_MUX = 2'b00;
    localparam logic [1:0] WD_PC4 = 2'b01;

    // Map an opcode/func pair onto the supported instruction set.
    function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
        instr_t c;
        c = I_ILLEGAL;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: c = I_ADD;
                    6'b100010: c = I_SUB;
                    6'b100100: c = I_AND;
                    6'b100101: c = I_OR;
                    6'b101010: c = I_SLT;
                    6'b001000: c = I_JR;
                    default:   c = I_ILLEGAL;
                endcase
            end
            6'b100011: c = I_LW;
            6'b101011: c = I_SW;
            6'b000100: c = I_BEQ;
            6'b001000: c = I_ADDI;
            6'b001010: c = I_SLTI;
            6'b000010: c = I_J;
            6'b000011: c = I_JAL;
            default:   c = I_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t      state_reg, state_next;
    logic [5:0]  opcode_reg, func_reg;
    logic        illegal_reg;
    logic [15:0] retired_reg;
    instr_t      live_instr;   // legality check uses the bus during DECODE
    instr_t      cur_instr;    // everything after DECODE uses the latched copy
    logic        is_rtype_alu;

    assign live_instr   = classify(opcode, func);
    assign cur_instr    = classify(opcode_reg, func_reg);
    assign is_rtype_alu = (cur_instr == I_ADD) || (cur_instr == I_SUB) ||
                          (cur_instr == I_AND) || (cur_instr == I_OR)  ||
                          (cur_instr == I_SLT);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Instruction latch, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_reg  <= 6'd0;
            func_reg    <= 6'd0;
            illegal_reg <= 1'b0;
            retired_reg <= 16'd0;
        end else begin
            if (state_reg == S_DECODE) begin
                opcode_reg <= opcode;
                func_reg   <= func;
                if (live_instr == I_ILLEGAL) begin
                    illegal_reg <= 1'b1;
                end
            end
            if (pc_en) begin
                retired_reg <= retired_reg + 16'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (en) state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = (live_instr == I_ILLEGAL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (cur_instr)
                    I_BEQ, I_J, I_JAL, I_JR: state_next = S_FETCH;
                    I_LW, I_SW:              state_next = S_MEM;
                    default:                 state_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_next = (cur_instr == I_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB:    state_next = S_FETCH;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    // Output decode. Everything is a function of state and the latched
    // instruction, except the sw completion in MEM: its write strobe and
    // pc_en must coincide with the cycle the memory reports ready.
    always_comb begin
        MemtoReg     = 1'b0;
        Reg_Write    = 1'b0;
        Mem_Read     = 1'b0;
        Mem_Write    = 1'b0;
        Branch       = 1'b0;
        ALUsrc       = 1'b0;
        JrSel        = 1'b0;
        Jump         = 1'b0;
        regDst       = RD_RT;
        writeDst     = WD_MUX;
        ALUOperation = ALU_AND;
        pc_en        = 1'b0;

        // ALU setup is held steady from EXEC through write-back.
        if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
            case (cur_instr)
                I_LW, I_SW, I_ADDI: begin
                    ALUsrc       = 1'b1;
                    ALUOperation = ALU_ADD;
                end
                I_SLTI: begin
                    ALUsrc       = 1'b1;
                    ALUOperation = ALU_SLT;
                end
                I_BEQ:   ALUOperation = ALU_SUB;
                I_ADD:   ALUOperation = ALU_ADD;
                I_SUB:   ALUOperation = ALU_SUB;
                I_AND:   ALUOperation = ALU_AND;
                I_OR:    ALUOperation = ALU_OR;
                I_SLT:   ALUOperation = ALU_SLT;
                default: ALUOperation = ALU_AND;
            endcase
        end

        case (state_reg)
            S_EXEC: begin
                case (cur_instr)
                    I_BEQ: begin
                        Branch = 1'b1;
                        pc_en  = 1'b1;
                    end
                    I_J: begin
                        Jump  = 1'b1;
                        pc_en = 1'b1;
                    end
                    I_JAL: begin
                        Jump      = 1'b1;
                        Reg_Write = 1'b1;
                        regDst    = RD_R31;
                        writeDst  = WD_PC4;
                        pc_en     = 1'b1;
                    end
                    I_JR: begin
                        Jump  = 1'b1;
                        JrSel = 1'b1;
                        pc_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (cur_instr == I_LW) begin
                    Mem_Read = 1'b1;
                end
                if (cur_instr == I_SW && mem_ready) begin
                    Mem_Write = 1'b1;
                    pc_en     = 1'b1;
                end
            end
            S_WB: begin
                Reg_Write = 1'b1;
                pc_en     = 1'b1;
                regDst    = is_rtype_alu ? RD_RD : RD_RT;
                writeDst  = WD_MUX;
                if (cur_instr == I_LW) begin
                    Mem_Read = 1'b1;
                    MemtoReg = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign illegal = illegal_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
//
// Scoreboard bench for mc_controller. Each issued instruction pushes its
// expected completion record (latency, control vector, retire count); the
// record is popped and compared when the controller raises pc_en.
// Control vector layout: {MemtoReg, Reg_Write, Mem_Read, Mem_Write, Branch,
// ALUsrc, JrSel, Jump, regDst[1:0], writeDst[1:0], ALUOperation[3:0]}.
// -----------------------------------------------------------------------------
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset, en, mem_ready;
    logic [5:0]  opcode, func;
    logic        MemtoReg, Reg_Write, Mem_Read, Mem_Write, Branch, ALUsrc, JrSel, Jump;
    logic [1:0]  regDst, writeDst;
    logic [3:0]  ALUOperation;
    logic        pc_en, illegal;
    logic [15:0] retired;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .opcode       (opcode),
        .func         (func),
        .mem_ready    (mem_ready),
        .MemtoReg     (MemtoReg),
        .Reg_Write    (Reg_Write),
        .Mem_Read     (Mem_Read),
        .Mem_Write    (Mem_Write),
        .Branch       (Branch),
        .ALUsrc       (ALUsrc),
        .JrSel        (JrSel),
        .Jump         (Jump),
        .regDst       (regDst),
        .writeDst     (writeDst),
        .ALUOperation (ALUOperation),
        .pc_en        (pc_en),
        .illegal      (illegal),
        .retired      (retired)
    );

    typedef struct {
        string       name;
        int          latency;
        logic [15:0] ctrl;
        logic [15:0] retired;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] exp_retired;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs_ctrl();
        return {MemtoReg, Reg_Write, Mem_Read, Mem_Write, Branch, ALUsrc, JrSel, Jump,
                regDst, writeDst, ALUOperation};
    endfunction

    function automatic logic [15:0] cv(input logic [7:0] flags, input logic [1:0] rd,
                                       input logic [1:0] wd, input logic [3:0] alu);
        return {flags, rd, wd, alu};
    endfunction

    // Issue one instruction, scramble opcode/func after DECODE to prove they
    // are latched, and compare against the scoreboard when pc_en appears.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int wait_cycles, input int base_lat, input logic [15:0] ectrl);
        exp_t e;
        exp_t got_e;
        bit   done;
        int   lat;
        e.name      = name;
        e.latency   = base_lat + wait_cycles;
        e.ctrl      = ectrl;
        exp_retired = exp_retired + 16'd1;
        e.retired   = exp_retired;
        sb_q.push_back(e);

        @(negedge clk);
        en = 1'b1; opcode = op; func = fn; mem_ready = 1'b0;
        done = 1'b0;
        lat  = 0;
        for (int k = 2; k <= 40 && !done; k++) begin
            @(negedge clk);
            en = 1'b0;
            if (k >= 3) begin
                opcode = 6'($urandom);
                func   = 6'($urandom);
            end
            mem_ready = (k >= 4 + wait_cycles);
            #1;
            if (pc_en) begin
                done = 1'b1;
                lat  = k;
                check({name, " sb_depth"}, sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    got_e = sb_q.pop_front();
                    check({name, " latency"}, lat, got_e.latency);
                    check({name, " ctrl"}, obs_ctrl(), got_e.ctrl);
                    @(negedge clk);
                    #1;
                    check({name, " retired"}, retired, got_e.retired);
                    check({name, " pc_en_single"}, pc_en, 0);
                end
            end else begin
                check({name, " early_write"}, {Reg_Write, Mem_Write}, 2'b00);
            end
        end
        check({name, " completed"}, done, 1);
        $display("txn %-5s op=%b fn=%b wait=%0d latency=%0d retired=%0h",
                 name, op, fn, wait_cycles, lat, retired);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        #1;
        check("reset ctrl", obs_ctrl(), 16'h0000);
        check("reset pc_en", pc_en, 0);
        check("reset illegal", illegal, 0);
        check("reset retired", retired, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        exp_retired = 16'h0000;
    endtask

    task automatic run_illegal(input string name, input logic [5:0] op, input logic [5:0] fn);
        int pulses;
        pulses = 0;
        @(negedge clk);
        en = 1'b1; opcode = op; func = fn;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            #1;
            if (k == 3) check({name, " illegal_set"}, illegal, 1);
            if (pc_en || Reg_Write || Mem_Write) pulses++;
        end
        check({name, " halt_no_pulses"}, pulses, 0);
        check({name, " illegal_sticky"}, illegal, 1);
        $display("txn %-5s op=%b fn=%b halted illegal=%0b", name, op, fn, illegal);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mem_ready = 1'b0; opcode = 6'd0; func = 6'd0;
        exp_retired = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        check("por ctrl", obs_ctrl(), 16'h0000);
        check("por pc_en", pc_en, 0);
        check("por illegal", illegal, 0);
        check("por retired", retired, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        // Idle with en low: nothing may complete.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("idle pc_en", pc_en, 0);
        end

        run_instr("add",  6'b000000, 6'b100000, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0010));
        run_instr("sub",  6'b000000, 6'b100010, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0110));
        run_instr("and",  6'b000000, 6'b100100, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0000));
        run_instr("or",   6'b000000, 6'b100101, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0001));
        run_instr("slt",  6'b000000, 6'b101010, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0111));
        run_instr("jr",   6'b000000, 6'b001000, 0, 3, cv(8'b0000_0011, 2'b00, 2'b00, 4'b0000));
        run_instr("lw",   6'b100011, 6'b000000, 0, 5, cv(8'b1110_0100, 2'b00, 2'b00, 4'b0010));
        run_instr("lw",   6'b100011, 6'b010101, 3, 5, cv(8'b1110_0100, 2'b00, 2'b00, 4'b0010));
        run_instr("sw",   6'b101011, 6'b000000, 0, 4, cv(8'b0001_0100, 2'b00, 2'b00, 4'b0010));
        run_instr("sw",   6'b101011, 6'b111000, 2, 4, cv(8'b0001_0100, 2'b00, 2'b00, 4'b0010));
        run_instr("beq",  6'b000100, 6'b000000, 0, 3, cv(8'b0000_1000, 2'b00, 2'b00, 4'b0110));
        run_instr("addi", 6'b001000, 6'b100010, 0, 4, cv(8'b0100_0100, 2'b00, 2'b00, 4'b0010));
        run_instr("slti", 6'b001010, 6'b000000, 0, 4, cv(8'b0100_0100, 2'b00, 2'b00, 4'b0111));
        run_instr("j",    6'b000010, 6'b000000, 0, 3, cv(8'b0000_0001, 2'b00, 2'b00, 4'b0000));
        run_instr("jal",  6'b000011, 6'b000000, 0, 3, cv(8'b0100_0001, 2'b10, 2'b01, 4'b0000));

        // Retire-counter wrap: preload near the top instead of issuing 65535 beqs.
        @(negedge clk);
        force dut.retired_reg = 16'hFFFE;
        #1;
        release dut.retired_reg;
        #1;
        check("preload retired", retired, 16'hFFFE);
        exp_retired = 16'hFFFE;
        run_instr("beq",  6'b000100, 6'b000000, 0, 3, cv(8'b0000_1000, 2'b00, 2'b00, 4'b0110));
        run_instr("beq",  6'b000100, 6'b000000, 0, 3, cv(8'b0000_1000, 2'b00, 2'b00, 4'b0110));
        check("wrap retired", retired, 16'h0000);

        // sw aborted by reset during a MEM wait.
        @(negedge clk);
        en = 1'b1; opcode = 6'b101011; func = 6'd0; mem_ready = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            en = 1'b0;
            #1;
            check("sw_abort pre_write", Mem_Write, 0);
        end
        reset = 1'b0;
        #1;
        check("sw_abort ctrl", obs_ctrl(), 16'h0000);
        check("sw_abort pc_en", pc_en, 0);
        check("sw_abort retired", retired, 16'h0000);
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("sw_abort held", {pc_en, Mem_Write, Reg_Write}, 3'b000);
        end
        reset = 1'b1;
        exp_retired = 16'h0000;
        $display("txn sw    aborted by reset during MEM wait");
        run_instr("sw",   6'b101011, 6'b000000, 1, 4, cv(8'b0001_0100, 2'b00, 2'b00, 4'b0010));

        // Undefined instructions halt until reset.
        run_illegal("ill_op", 6'b111111, 6'b000000);
        do_reset();
        run_illegal("ill_fn", 6'b000000, 6'b000001);
        do_reset();
        run_instr("add",  6'b000000, 6'b100000, 0, 4, cv(8'b0100_0000, 2'b01, 2'b00, 4'b0010));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port en, input, 1, run enable; sampled only in FETCH.
REQ-004 SHALL have ports opcode and func, input, 6 each, instruction[31:26] and [5:0] from the datapath.
REQ-005 SHALL have port mem_ready, input, 1, data-memory ready for the current access.
REQ-006 SHALL have ports MemtoReg, Reg_Write, Mem_Read, Mem_Write, Branch, ALUsrc, JrSel, Jump, output, 1 each, datapath controls.
REQ-007 SHALL have ports regDst and writeDst, output, 2 each: regDst 00=rt, 01=rd, 10=r31; writeDst 00=mem/ALU mux, 01=PC+4, 10=ALU result.
REQ-008 SHALL have port ALUOperation, output, 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-009 SHALL have port pc_en, output, 1, PC update strobe.
REQ-010 SHALL have port illegal, output, 1, sticky undefined-instruction flag.
REQ-011 SHALL have port retired, output, 16, count of completed instructions.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-013 FETCH: stay while en=0; otherwise go to DECODE next cycle.
REQ-014 DECODE: if opcode/func is unsupported, go to HALT and set illegal; otherwise go to EXEC.
REQ-015 Supported instructions: R-type 000000 with func add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000; lw 100011; sw 101011; beq 000100; addi 001000; slti 001010; j 000010; jal 000011.
REQ-016 EXEC transitions: beq, j, jal and jr complete in EXEC and return to FETCH; lw and sw go to MEM; R-type ALU ops, addi and slti go to WB.
REQ-017 MEM: hold while mem_ready=0. When mem_ready=1, sw completes (to FETCH) and lw goes to WB.
REQ-018 WB: completes; next state FETCH.
REQ-019 Completion cycle SHALL assert pc_en=1 for exactly one cycle; pc_en SHALL be 0 in every other cycle.
REQ-020 Reg_Write and Mem_Write SHALL be asserted only in the completion cycle, so each fires at most once per instruction.
REQ-021 ALUsrc=1 for lw, sw, addi and slti in EXEC, MEM and WB.
REQ-022 ALUOperation in EXEC/MEM/WB: ADD for lw/sw/addi; SUB for beq; SLT for slti; per func for R-type.
REQ-023 Mem_Read=1 for lw in MEM and WB. MemtoReg=1 for lw in WB.
REQ-024 Register writes: R-type uses regDst=01, writeDst=00. lw/addi/slti use regDst=00, writeDst=00. jal uses regDst=10, writeDst=01.
REQ-025 Branch=1 for beq in EXEC; the taken decision is the datapath's Zero AND Branch.
REQ-026 Jump=1 for j, jal and jr in EXEC. JrSel=1 for jr only.
REQ-027 All controls not listed for a state SHALL be 0. Outputs SHALL be Moore-style (decoded from state plus the latched opcode/func).
REQ-028 opcode/func SHALL be latched on the DECODE cycle and used through completion.
REQ-029 Latency in cycles with mem_ready=1: beq/j/jal/jr 3; R-type/addi/slti/sw 4; lw 5. Each MEM wait cycle adds 1.
REQ-030 retired SHALL increment on each pc_en cycle and wrap from FFFF to 0000.
REQ-031 HALT SHALL be held until reset: pc_en=0, Reg_Write=0, Mem_Write=0, illegal=1.

Reset
REQ-032 While reset=0: state FETCH, all outputs 0, retired=0, illegal=0, latched opcode/func=0. Reset is asynchronous and takes effect immediately.
REQ-033 Reset asserted mid-instruction (including during a MEM wait) SHALL abort the instruction with no pc_en, Reg_Write or Mem_Write pulse.
REQ-034 After reset deasserts, the first transition out of FETCH SHALL occur on the first rising edge where en=1.

Verification
REQ-035 add (opcode 000000, func 100000), en=1 -> pc_en on cycle 4 with Reg_Write=1, regDst=01, writeDst=00, ALUOperation=0010; retired=1.
REQ-036 lw with mem_ready low for 3 cycles -> MEM held 3 extra cycles, completion on cycle 8 with MemtoReg=1, Reg_Write=1; Mem_Write never 1.
REQ-037 jal -> completion on cycle 3 with Jump=1, Reg_Write=1, regDst=10, writeDst=01, JrSel=0; jr -> Jump=1, JrSel=1, Reg_Write=0.
REQ-038 opcode 111111 -> HALT after DECODE, illegal=1, no further pc_en; reset=0 clears illegal.
REQ-039 Preload retired to FFFF via 65535 beq instructions, run one more -> retired=0000.
REQ-040 sw with reset pulsed low during a MEM wait -> no Mem_Write, all outputs 0; after release and en=1 the sw restarts from FETCH.
